// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the LCD rectangle-fill controller.
//   - panel dimensions (last valid column/row index)
//   - panel command bytes used in the address/write header
//   - FSM state encoding
//   - RGB565 colour constants
//   - hdr_byte(): header byte generator for the 11-byte address sequence
package lcd_pkg;

    localparam logic [8:0] H_MAX = 9'd239;
    localparam logic [8:0] V_MAX = 9'd319;

    localparam logic [7:0] CASET = 8'h2A;
    localparam logic [7:0] RASET = 8'h2B;
    localparam logic [7:0] RAMWR = 8'h2C;

    localparam logic [3:0] HDR_LAST  = 4'd10;
    localparam int         PIX_CNT_W = 18;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PIX  = 2'd2
    } state_t;

    localparam logic [15:0] RGB565_BLACK = 16'h0000;
    localparam logic [15:0] RGB565_WHITE = 16'hFFFF;
    localparam logic [15:0] RGB565_RED   = 16'hF800;
    localparam logic [15:0] RGB565_GREEN = 16'h07E0;
    localparam logic [15:0] RGB565_BLUE  = 16'h001F;

    // Byte idx of the header: CASET x0 x1 RASET y0 y1 RAMWR.
    // Bit 8 is the D/C flag: 0 for commands, 1 for parameters.
    function automatic logic [8:0] hdr_byte(input logic [3:0] idx,
                                            input logic [8:0] x0,
                                            input logic [8:0] x1,
                                            input logic [8:0] y0,
                                            input logic [8:0] y1);
        logic [8:0] b;
        case (idx)
            4'd0:    b = {1'b0, CASET};
            4'd1:    b = {1'b1, 7'b0000000, x0[8]};
            4'd2:    b = {1'b1, x0[7:0]};
            4'd3:    b = {1'b1, 7'b0000000, x1[8]};
            4'd4:    b = {1'b1, x1[7:0]};
            4'd5:    b = {1'b0, RASET};
            4'd6:    b = {1'b1, 7'b0000000, y0[8]};
            4'd7:    b = {1'b1, y0[7:0]};
            4'd8:    b = {1'b1, 7'b0000000, y1[8]};
            4'd9:    b = {1'b1, y1[7:0]};
            4'd10:   b = {1'b0, RAMWR};
            default: b = 9'h000;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/lcd_draw_ctrl_if.sv
// lcd_draw_ctrl_if: rectangle-fill request channel.
//   req_valid / req_ready : handshake, accept when both are 1
//   req_x0, req_x1        : column start/end (inclusive)
//   req_y0, req_y1        : row start/end (inclusive)
//   req_color             : RGB565 fill colour
//   req_err               : one-cycle pulse when a request is rejected
// master = requester, slave = lcd_draw_ctrl.
interface lcd_draw_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [8:0]  req_x0;
    logic [8:0]  req_x1;
    logic [8:0]  req_y0;
    logic [8:0]  req_y1;
    logic [15:0] req_color;
    logic        req_err;

    modport master (output req_valid, req_x0, req_x1, req_y0, req_y1, req_color,
                    input  req_ready, req_err);
    modport slave  (input  req_valid, req_x0, req_x1, req_y0, req_y1, req_color,
                    output req_ready, req_err);
endinterface

// File: rtl/lcd_rect_calc.sv
// lcd_rect_calc: validates (and optionally clips) a fill request and
// computes its pixel byte count. The check is combinational so the FSM can
// leave IDLE on the accept edge; the latched rectangle, colour, byte count
// and the reject pulse are registered on that same edge.
// Optional feature: LCD_DRAW_CLIP_EN clips x1/y1 to the panel edge.
// Ports:
//   sys_clk_50MHz, sys_rst_n : clock, async active-low reset
//   accept                   : request handshake this cycle
//   x0,x1,y0,y1,color        : raw request fields
//   ok                       : request is valid (combinational)
//   err                      : registered reject pulse
//   rx0,rx1,ry0,ry1,rcolor   : latched (clipped) rectangle and colour
//   pix_total                : latched pixel byte count, 2*w*h
module lcd_rect_calc import lcd_pkg::*; (
    input  logic                 sys_clk_50MHz,
    input  logic                 sys_rst_n,
    input  logic                 accept,
    input  logic [8:0]           x0,
    input  logic [8:0]           x1,
    input  logic [8:0]           y0,
    input  logic [8:0]           y1,
    input  logic [15:0]          color,
    output logic                 ok,
    output logic                 err,
    output logic [8:0]           rx0,
    output logic [8:0]           rx1,
    output logic [8:0]           ry0,
    output logic [8:0]           ry1,
    output logic [15:0]          rcolor,
    output logic [PIX_CNT_W-1:0] pix_total
);

    logic [8:0]           x1_c_s, y1_c_s, w_s, h_s;
    logic [16:0]          area_s;
    logic                 err_d, err_q;
    logic [8:0]           x0_d, x0_q, x1_d, x1_q, y0_d, y0_q, y1_d, y1_q;
    logic [15:0]          color_d, color_q;
    logic [PIX_CNT_W-1:0] total_d, total_q;

    // Validation / clipping and byte-count arithmetic.
    always_comb begin
`ifdef LCD_DRAW_CLIP_EN
        x1_c_s = (x1 > H_MAX) ? H_MAX : x1;
        y1_c_s = (y1 > V_MAX) ? V_MAX : y1;
        ok     = (x0 <= H_MAX) && (y0 <= V_MAX) && (x0 <= x1_c_s) && (y0 <= y1_c_s);
`else
        x1_c_s = x1;
        y1_c_s = y1;
        ok     = (x0 <= x1) && (y0 <= y1) && (x1 <= H_MAX) && (y1 <= V_MAX);
`endif
        // Only meaningful when ok; widths fit since w <= 240, h <= 320.
        w_s    = x1_c_s - x0 + 9'd1;
        h_s    = y1_c_s - y0 + 9'd1;
        area_s = {8'd0, w_s} * {8'd0, h_s};
    end

    // Next values of the latched request fields.
    always_comb begin
        x0_d    = x0_q;
        x1_d    = x1_q;
        y0_d    = y0_q;
        y1_d    = y1_q;
        color_d = color_q;
        total_d = total_q;
        err_d   = 1'b0;
        if (accept) begin
            x0_d    = x0;
            x1_d    = x1_c_s;
            y0_d    = y0;
            y1_d    = y1_c_s;
            color_d = color;
            total_d = {area_s, 1'b0};
            err_d   = ~ok;
        end else begin
            err_d   = 1'b0;
        end
    end

    // Request field registers.
    always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            x0_q    <= 9'd0;
            x1_q    <= 9'd0;
            y0_q    <= 9'd0;
            y1_q    <= 9'd0;
            color_q <= 16'd0;
            total_q <= '0;
            err_q   <= 1'b0;
        end else begin
            x0_q    <= x0_d;
            x1_q    <= x1_d;
            y0_q    <= y0_d;
            y1_q    <= y1_d;
            color_q <= color_d;
            total_q <= total_d;
            err_q   <= err_d;
        end
    end

    assign err       = err_q;
    assign rx0       = x0_q;
    assign rx1       = x1_q;
    assign ry0       = y0_q;
    assign ry1       = y1_q;
    assign rcolor    = color_q;
    assign pix_total = total_q;

endmodule

// File: rtl/lcd_draw_ctrl.sv
// lcd_draw_ctrl: rectangle-fill controller for an SPI LCD. After panel
// init it sends the CASET/RASET/RAMWR header for the requested rectangle,
// then streams the RGB565 colour (high byte first) for every pixel, one
// byte per wr_done from the SPI byte writer. Before init_done the init
// sequencer drives the byte writer directly.
// Optional feature: LCD_DRAW_CLIP_EN (see lcd_rect_calc).
// Ports:
//   sys_clk_50MHz, sys_rst_n : clock, async active-low reset
//   init_done                : panel init complete (level)
//   init_data, init_en_write : init sequencer byte and enable (pass-through)
//   wr_done                  : byte sent pulse from the SPI byte writer
//   req_if (slave)           : fill request channel
//   lcd_data, lcd_en_write   : byte and enable to the SPI byte writer
//   busy                     : fill in progress
module lcd_draw_ctrl import lcd_pkg::*; (
    input  logic             sys_clk_50MHz,
    input  logic             sys_rst_n,
    input  logic             init_done,
    input  logic [8:0]       init_data,
    input  logic             init_en_write,
    input  logic             wr_done,
    lcd_draw_ctrl_if.slave   req_if,
    output logic [8:0]       lcd_data,
    output logic             lcd_en_write,
    output logic             busy
);

    state_t               state_d, state_q;
    logic [3:0]           hdr_idx_d, hdr_idx_q;
    logic [PIX_CNT_W-1:0] pix_cnt_d, pix_cnt_q, pix_nxt_s;
    logic [8:0]           data_d, data_q;
    logic                 en_d, en_q, busy_d, busy_q, ready_d, ready_q;
    logic                 accept_s, ok_s;
    logic [8:0]           rx0_s, rx1_s, ry0_s, ry1_s;
    logic [15:0]          rcolor_s;
    logic [PIX_CNT_W-1:0] pix_total_s;

    assign req_if.req_ready = ready_q & init_done;
    assign accept_s         = req_if.req_valid & ready_q & init_done;

    lcd_rect_calc u_calc (
        .sys_clk_50MHz (sys_clk_50MHz),
        .sys_rst_n     (sys_rst_n),
        .accept        (accept_s),
        .x0            (req_if.req_x0),
        .x1            (req_if.req_x1),
        .y0            (req_if.req_y0),
        .y1            (req_if.req_y1),
        .color         (req_if.req_color),
        .ok            (ok_s),
        .err           (req_if.req_err),
        .rx0           (rx0_s),
        .rx1           (rx1_s),
        .ry0           (ry0_s),
        .ry1           (ry1_s),
        .rcolor        (rcolor_s),
        .pix_total     (pix_total_s)
    );

    // Next-state and output-register logic.
    always_comb begin
        state_d   = state_q;
        hdr_idx_d = hdr_idx_q;
        pix_cnt_d = pix_cnt_q;
        data_d    = data_q;
        en_d      = en_q;
        busy_d    = busy_q;
        pix_nxt_s = pix_cnt_q + 18'd1;
        case (state_q)
            ST_IDLE: begin
                en_d   = 1'b0;
                busy_d = 1'b0;
                // wr_done is deliberately not looked at here.
                if (accept_s && ok_s) begin
                    state_d   = ST_HDR;
                    hdr_idx_d = 4'd0;
                    pix_cnt_d = '0;
                    data_d    = {1'b0, CASET};
                    en_d      = 1'b1;
                    busy_d    = 1'b1;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (!init_done) begin
                    state_d = ST_IDLE;
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                end else if (wr_done) begin
                    if (hdr_idx_q == HDR_LAST) begin
                        state_d   = ST_PIX;
                        pix_cnt_d = '0;
                        data_d    = {1'b1, rcolor_s[15:8]};
                    end else begin
                        hdr_idx_d = hdr_idx_q + 4'd1;
                        data_d    = hdr_byte(hdr_idx_q + 4'd1, rx0_s, rx1_s, ry0_s, ry1_s);
                    end
                end else begin
                    state_d = ST_HDR;
                end
            end
            ST_PIX: begin
                if (!init_done) begin
                    state_d = ST_IDLE;
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                end else if (wr_done) begin
                    if (pix_cnt_q == pix_total_s - 18'd1) begin
                        state_d = ST_IDLE;
                        en_d    = 1'b0;
                        busy_d  = 1'b0;
                    end else begin
                        // Even byte index carries the high colour byte.
                        pix_cnt_d = pix_nxt_s;
                        data_d    = pix_nxt_s[0] ? {1'b1, rcolor_s[7:0]}
                                                 : {1'b1, rcolor_s[15:8]};
                    end
                end else begin
                    state_d = ST_PIX;
                end
            end
            default: begin
                state_d = ST_IDLE;
                en_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    // FSM state, counters and output registers.
    always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= ST_IDLE;
            hdr_idx_q <= 4'd0;
            pix_cnt_q <= '0;
            data_q    <= 9'h000;
            en_q      <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hdr_idx_q <= hdr_idx_d;
            pix_cnt_q <= pix_cnt_d;
            data_q    <= data_d;
            en_q      <= en_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
        end
    end

    // Init sequencer owns the byte writer until the panel is ready.
    assign lcd_data     = init_done ? data_q : init_data;
    assign lcd_en_write = init_done ? en_q   : init_en_write;
    assign busy         = busy_q;

endmodule
